sram_rw_pipelined: RTL and testbench

Parametrised single-port SRAM behavioural model, successor to the fixed 64x32 OpenRAM model used for HDC hypervector and class-memory storage. Adds arbitrary depth, per-byte write mask, valid/ready request handshake and a configurable read-latency pipeline. Adds an on-chip zero-initialisation FSM (after reset or on request) and out-of-range address detection. Sits between the HDC datapath controllers and the memory macro boundary; synthesis later swaps the storage array for the macro.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_rd_pipe.sv | 47 ++++
 rtl/sram_rw_pipelined.sv | 104 ++++++++++
 tb/tb_sram_rw_pipelined.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the parametrised single-port SRAM model.
package sram_pkg;

  localparam int MAX_READ_LATENCY = 4;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

  function automatic int mask_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-response shift register: valid/data/err stages, LATENCY deep.
module sram_rd_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_err,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  logic [LATENCY:1]                 vld_pipe;
  logic [LATENCY:1]                 err_pipe;
  logic [LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

  // Data stages only load behind a valid bit, so the last stage holds the
  // most recent response while nothing is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_valid;
      if (in_valid) begin
        dat_pipe[1] <= in_data;
        err_pipe[1] <= in_err;
      end
      for (int s = 2; s <= LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) begin
          dat_pipe[s] <= dat_pipe[s-1];
          err_pipe[s] <= err_pipe[s-1];
        end
      end
    end
  end

  assign out_valid = vld_pipe[LATENCY];
  assign out_data  = dat_pipe[LATENCY];
  assign out_err   = vld_pipe[LATENCY] & err_pipe[LATENCY];

endmodule

// File: rtl/sram_rw_pipelined.sv
// Single-port SRAM model: byte-masked writes, valid/ready requests,
// pipelined reads, zero-init FSM and out-of-range detection.
module sram_rw_pipelined
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 32,
  parameter int ADDR_WIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int READ_LATENCY  = 1,
  parameter bit INIT_ON_RESET = 1'b1,
  parameter int MASK_WIDTH    = mask_width(DATA_WIDTH)
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MASK_WIDTH-1:0] req_wmask,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  input  logic                  init_start,
  output logic                  init_busy
);

  localparam int LAT = (READ_LATENCY < 1) ? 1 :
                       (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  sram_state_e           state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  in_range, wr_acc, rd_acc;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state <= INIT_ON_RESET ? ST_INIT : ST_READY;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_INIT: begin
        if (ptr == LAST_PTR) begin
          state_nxt = ST_READY;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        if (init_start) begin
          state_nxt = ST_INIT;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = ST_READY;
    endcase
  end

  // init_start steals the cycle so a request never races the FSM entry.
  assign req_ready = !rst0 && (state == ST_READY) && !init_start;
  assign init_busy = (state == ST_INIT);
  assign in_range  = ({1'b0, req_addr} < DEPTH_W);
  assign wr_acc    = req_valid && req_ready && req_we && in_range;
  assign rd_acc    = req_valid && req_ready && !req_we;
  assign rd_word   = in_range ? mem[req_addr] : '0;

  // Storage is deliberately unreset; only the init FSM clears it.
  always_ff @(posedge clk0) begin
    if (!rst0 && state == ST_INIT) begin
      mem[ptr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (req_wmask[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (LAT)
  ) u_rd_pipe (
    .clk       (clk0),
    .rst       (rst0),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .in_err    (!in_range),
    .out_valid (rsp_valid),
    .out_data  (rsp_rdata),
    .out_err   (rsp_err)
  );

endmodule

// File: tb/tb_sram_rw_pipelined.sv
// Randomised and directed bench for sram_rw_pipelined against a word-array model.
module tb_sram_rw_pipelined;

  localparam int DW    = 64;
  localparam int DEPTH = 20;
  localparam int AW    = 5;
  localparam int LAT   = 3;
  localparam int MW    = 8;

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [MW-1:0] req_wmask = '0;
  logic          init_start = 1'b0;
  logic          req_ready, rsp_valid, rsp_err, init_busy;
  logic [DW-1:0] rsp_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic        err;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            rem = DEPTH;
  logic [DW-1:0] last_rdata = '0;

  sram_rw_pipelined #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .ADDR_WIDTH    (AW),
    .READ_LATENCY  (LAT),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .clk0       (clk0),
    .rst0       (rst0),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_start (init_start),
    .init_busy  (init_busy)
  );

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc++;

  // Reference model: decides acceptance from its own init countdown and
  // checks every response cycle-by-cycle against the expected queue.
  always @(negedge clk0) begin
    exp_t e;
    if (rst0) begin
      expq.delete();
      last_rdata = '0;
      rem = DEPTH;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else begin
      checks++;
      if (init_busy !== (rem > 0)) begin
        errors++;
        $display("FAIL busy @%0d: got %b want %b", cyc, init_busy, (rem > 0));
      end
      checks++;
      if (req_ready !== (rem == 0 && !init_start)) begin
        errors++;
        $display("FAIL ready @%0d: got %b want %b", cyc, req_ready, (rem == 0 && !init_start));
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e.data || rsp_err !== e.err) begin
          errors++;
          $display("FAIL rsp @%0d: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                   cyc, rsp_valid, rsp_rdata, rsp_err, e.data, e.err);
        end
        last_rdata = e.data;
      end else begin
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== last_rdata) begin
          errors++;
          $display("FAIL idle @%0d: got v=%b d=%h e=%b want v=0 d=%h e=0",
                   cyc, rsp_valid, rsp_rdata, rsp_err, last_rdata);
        end
      end
      if (rem > 0) begin
        rem--;
      end else if (init_start) begin
        rem = DEPTH;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end else if (req_valid) begin
        if (req_we) begin
          if (int'(req_addr) < DEPTH)
            for (int i = 0; i < MW; i++)
              if (req_wmask[i]) model_mem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
        end else begin
          e.due  = cyc + LAT;
          e.err  = (int'(req_addr) >= DEPTH);
          e.data = e.err ? '0 : model_mem[req_addr];
          expq.push_back(e);
        end
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic do_req(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
    int t = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
    @(negedge clk0);
    while (!req_ready && t < 100) begin t++; @(negedge clk0); end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL handshake: req_ready=%b after %0d cycles, want 1", req_ready, t);
    end
    @(posedge clk0); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic ok);
    int t = 0;
    ok = 1'b0;
    while (t < 20 && !ok) begin
      @(negedge clk0);
      if (rsp_valid) ok = 1'b1;
      t++;
    end
  endtask

  task automatic count_init(output int n);
    n = 0;
    @(negedge clk0);
    while (init_busy === 1'b1 && n < 200) begin n++; @(negedge clk0); end
  endtask

  task automatic test_reset();
    int n;
    rst0 = 1'b1;
    repeat (2) @(posedge clk0);
    @(negedge clk0);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", rsp_err); end
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", init_busy); end
    @(posedge clk0); #1;
    rst0 = 1'b0;
    count_init(n);
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL init_len: got %0d want %0d", n, DEPTH); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL init_ready: got %b want 1", req_ready); end
    @(posedge clk0); #1;
  endtask

  task automatic test_init_zero();
    int n = 0;
    fork
      for (int a = 0; a < DEPTH; a++) do_req(1'b0, AW'(a), '0, '0);
      for (int t = 0; t < DEPTH + 30 && n < DEPTH; t++) begin
        @(negedge clk0);
        if (rsp_valid) begin
          checks++;
          if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_rd %0d: got d=%h e=%b want d=0 e=0", n, rsp_rdata, rsp_err);
          end
          n++;
        end
      end
    join
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL zero_cnt: got %0d want %0d", n, DEPTH); end
    @(posedge clk0); #1;
  endtask

  task automatic test_mask();
    logic ok;
    do_req(1'b1, 5'd5, 64'h1122334455667788, 8'hFF);
    do_req(1'b1, 5'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    do_req(1'b0, 5'd5, '0, '0);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_rdata !== 64'h11223344AAAAAAAA) begin
      errors++; $display("FAIL mask: got ok=%b d=%h want d=11223344aaaaaaaa", ok, rsp_rdata);
    end
    @(posedge clk0); #1;
    do_req(1'b1, 5'd5, '1, 8'h00);
    do_req(1'b0, 5'd5, '0, '0);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_rdata !== 64'h11223344AAAAAAAA) begin
      errors++; $display("FAIL mask_zero: got ok=%b d=%h want d=11223344aaaaaaaa", ok, rsp_rdata);
    end
    @(posedge clk0); #1;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w [3];
    int c0, n;
    for (int i = 0; i < 3; i++) begin
      w[i] = {$urandom, $urandom};
      do_req(1'b1, AW'(i + 1), w[i], 8'hFF);
    end
    c0 = cyc;
    for (int i = 0; i < 3; i++) do_req(1'b0, AW'(i + 1), '0, '0);
    n = 0;
    for (int t = 0; t < 20 && n < 3; t++) begin
      @(negedge clk0);
      if (rsp_valid) begin
        checks++;
        if (cyc !== c0 + n + LAT || rsp_rdata !== w[n]) begin
          errors++;
          $display("FAIL b2b %0d: got cyc=%0d d=%h want cyc=%0d d=%h", n, cyc, rsp_rdata, c0 + n + LAT, w[n]);
        end
        n++;
      end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_cnt: got %0d want 3", n); end
    @(posedge clk0); #1;
  endtask

  task automatic test_oob();
    logic ok;
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    do_req(1'b1, 5'd25, d, 8'hFF);
    do_req(1'b0, 5'd25, '0, '0);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_err !== 1'b1 || rsp_rdata !== '0) begin
      errors++; $display("FAIL oob25: got ok=%b e=%b d=%h want e=1 d=0", ok, rsp_err, rsp_rdata);
    end
    @(posedge clk0); #1;
    do_req(1'b0, AW'(DEPTH), '0, '0);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_err !== 1'b1 || rsp_rdata !== '0) begin
      errors++; $display("FAIL oob_edge: got ok=%b e=%b d=%h want e=1 d=0", ok, rsp_err, rsp_rdata);
    end
    @(posedge clk0); #1;
    do_req(1'b1, AW'(DEPTH - 1), d, 8'hFF);
    do_req(1'b0, AW'(DEPTH - 1), '0, '0);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_err !== 1'b0 || rsp_rdata !== d) begin
      errors++; $display("FAIL last_word: got ok=%b e=%b d=%h want e=0 d=%h", ok, rsp_err, rsp_rdata, d);
    end
    @(posedge clk0); #1;
    for (int a = 0; a < DEPTH; a++) do_req(1'b0, AW'(a), '0, '0);
    repeat (LAT + 1) @(posedge clk0);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_we     = $urandom_range(0, 1);
      req_addr   = AW'($urandom_range(0, 31));
      req_wdata  = {$urandom, $urandom};
      req_wmask  = MW'($urandom);
      init_start = ($urandom_range(0, 59) == 0);
      @(posedge clk0); #1;
    end
    req_valid = 1'b0; init_start = 1'b0;
    repeat (DEPTH + LAT + 2) @(posedge clk0);
    #1;
  endtask

  task automatic test_init_start();
    logic ok;
    logic [DW-1:0] got_first = 'x;
    int nb = 0, t = 0;
    do_req(1'b1, 5'd7, 64'hDEAD, 8'hFF);
    do_req(1'b0, 5'd7, '0, '0);
    init_start = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd7;
    @(posedge clk0); #1;
    init_start = 1'b0;
    @(negedge clk0);
    while (!req_ready && t < 200) begin
      if (rsp_valid) got_first = rsp_rdata;
      if (init_busy) nb++;
      t++;
      @(negedge clk0);
    end
    checks++; if (got_first !== 64'hDEAD) begin errors++; $display("FAIL preinit_rd: got %h want dead", got_first); end
    checks++; if (nb !== DEPTH) begin errors++; $display("FAIL reinit_len: got %0d want %0d", nb, DEPTH); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL held_ready: got %b want 1", req_ready); end
    @(posedge clk0); #1;
    req_valid = 1'b0;
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL held_rd: got ok=%b d=%h e=%b want d=0 e=0", ok, rsp_rdata, rsp_err);
    end
    @(posedge clk0); #1;
  endtask

  task automatic test_reset_mid_init();
    logic ok;
    logic [DW-1:0] d;
    int n;
    d = {$urandom, $urandom} | 64'h1;
    do_req(1'b1, 5'd3, d, 8'hFF);
    do_req(1'b0, 5'd3, '0, '0);
    wait_rsp(ok);
    @(posedge clk0); #1;
    init_start = 1'b1;
    @(posedge clk0); #1;
    init_start = 1'b0;
    repeat (10) @(posedge clk0);
    #1;
    checks++; if (rsp_rdata !== d) begin errors++; $display("FAIL hold_rdata: got %h want %h", rsp_rdata, d); end
    rst0 = 1'b1;
    #1;
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL mid_rst_rdata: got %h want 0", rsp_rdata); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", req_ready); end
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy: got %b want 1", init_busy); end
    @(posedge clk0); #1;
    rst0 = 1'b0;
    count_init(n);
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL mid_rst_len: got %0d want %0d", n, DEPTH); end
    @(posedge clk0); #1;
    do_req(1'b0, 5'd3, '0, '0);
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_rdata !== '0) begin errors++; $display("FAIL mid_rst_rd: got ok=%b d=%h want 0", ok, rsp_rdata); end
    @(posedge clk0); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_zero();
    test_mask();
    test_back_to_back();
    test_oob();
    test_random();
    test_init_start();
    test_reset_mid_init();
    repeat (LAT + 4) @(posedge clk0);
    @(negedge clk0);
    checks++;
    if (expq.size() != 0) begin
      errors++; $display("FAIL drain: got %0d pending responses want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
